// File: rtl/bp_fe_cmd_sequencer_if.sv
// FE command types and the sequencer's BE-side / FE-side handshake bundle.
// slave = sequencer side, master = BE producer plus FE consumer side.
package bp_fe_cmd_pkg;
    typedef enum logic [1:0] {e_bp_inv_cfg, e_bp_default_cfg} bp_params_e;

    localparam int vaddr_width_gp = 39;

    typedef enum logic [3:0] {
        e_op_state_reset,
        e_op_pc_redirection,
        e_op_icache_fill_response,
        e_op_icache_fence,
        e_op_itlb_fill_response,
        e_op_itlb_fence,
        e_op_attaboy,
        e_op_wait
    } bp_fe_command_queue_opcodes_e;

    typedef struct packed {
        logic [63:0]                  operands;
        logic [vaddr_width_gp-1:0]    vaddr;
        bp_fe_command_queue_opcodes_e opcode;
    } bp_fe_cmd_s;

    // Every supported configuration shares one command layout today.
    function automatic int fe_cmd_width(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return $bits(bp_fe_cmd_s);
            default:      return $bits(bp_fe_cmd_s);
        endcase
    endfunction
endpackage

interface bp_fe_cmd_sequencer_if #(parameter int els_p = 4);
    import bp_fe_cmd_pkg::*;

    bp_fe_cmd_s                   cmd_i;
    logic                         cmd_v_i;
    logic                         cmd_ready_o;
    bp_fe_cmd_s                   fe_cmd_o;
    logic                         fe_cmd_v_o;
    logic                         fe_cmd_yumi_i;
    logic                         fe_busy_i;
    logic                         flush_i;
    logic [$clog2(els_p+1)-1:0]   count_o;
    logic                         fence_pending_o;

    modport slave (
        input  cmd_i, cmd_v_i, fe_cmd_yumi_i, fe_busy_i, flush_i,
        output cmd_ready_o, fe_cmd_o, fe_cmd_v_o, count_o, fence_pending_o
    );

    modport master (
        output cmd_i, cmd_v_i, fe_cmd_yumi_i, fe_busy_i, flush_i,
        input  cmd_ready_o, fe_cmd_o, fe_cmd_v_o, count_o, fence_pending_o
    );
endinterface

// File: rtl/bp_fe_cmd_sequencer.sv
// In-order FE command buffer; fences wait at the head for quiesce_cycles_p idle FE cycles.
// Latency 1 cycle (non-fence); ready drops when full or flushing, head held until yumi.
module bp_fe_cmd_sequencer
    import bp_fe_cmd_pkg::*;
#(
    parameter bp_params_e bp_params_p      = e_bp_inv_cfg,
    parameter int         els_p            = 4,
    parameter int         quiesce_cycles_p = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_fe_cmd_sequencer_if.slave  bus
);
    localparam int fe_cmd_width_lp = fe_cmd_width(bp_params_p);
    localparam int ptr_w_lp        = $clog2(els_p);
    localparam int cnt_w_lp        = $clog2(els_p + 1);
    localparam int qcnt_w_lp       = $clog2(quiesce_cycles_p + 1);
    localparam logic [cnt_w_lp-1:0]  els_lp     = cnt_w_lp'(els_p);
    localparam logic [qcnt_w_lp-1:0] quiesce_lp = qcnt_w_lp'(quiesce_cycles_p);

    typedef enum logic [1:0] {e_empty, e_issue, e_quiesce, e_issue_fence} state_e;

    logic [fe_cmd_width_lp-1:0] mem_r [els_p];
    logic [ptr_w_lp-1:0]        wptr_r, rptr_r, succ_ptr;
    logic [cnt_w_lp-1:0]        count_r, count_n;
    logic [qcnt_w_lp-1:0]       qcnt_r, qcnt_n, qcnt_idle;
    state_e                     state_r, state_n;
    logic                       enq, deq, succ_fence;
    bp_fe_cmd_s                 succ;

    function automatic logic is_fence(bp_fe_cmd_s c);
        return (c.opcode == e_op_icache_fence) || (c.opcode == e_op_itlb_fence);
    endfunction

    assign bus.cmd_ready_o     = (count_r < els_lp) & ~bus.flush_i;
    assign enq                 = bus.cmd_v_i & bus.cmd_ready_o;
    assign deq                 = bus.fe_cmd_yumi_i & bus.fe_cmd_v_o;
    assign count_n             = bus.flush_i ? '0 : count_r + cnt_w_lp'(enq) - cnt_w_lp'(deq);

    assign bus.fe_cmd_o        = bp_fe_cmd_s'(mem_r[rptr_r]);
    assign bus.fe_cmd_v_o      = (state_r == e_issue) || (state_r == e_issue_fence);
    assign bus.fence_pending_o = (state_r == e_quiesce);
    assign bus.count_o         = count_r;

    // The entry that becomes head next cycle; when nothing else is buffered it is
    // the command arriving now, which is not yet in storage.
    assign succ_ptr   = rptr_r + ptr_w_lp'(deq);
    assign succ       = (count_r == cnt_w_lp'(deq)) ? bus.cmd_i : bp_fe_cmd_s'(mem_r[succ_ptr]);
    assign succ_fence = is_fence(succ);
    assign qcnt_idle  = bus.fe_busy_i ? '0 :
                        (qcnt_r == quiesce_lp) ? qcnt_r : qcnt_r + 1'b1;

    always_comb begin
        state_n = state_r;
        qcnt_n  = qcnt_r;
        case (state_r)
            e_empty: begin
                qcnt_n = '0;
                // The enqueue cycle itself counts toward quiescence.
                if (enq) begin
                    if (!succ_fence)
                        state_n = e_issue;
                    else if (!bus.fe_busy_i && quiesce_lp == qcnt_w_lp'(1))
                        state_n = e_issue_fence;
                    else begin
                        state_n = e_quiesce;
                        qcnt_n  = bus.fe_busy_i ? '0 : qcnt_w_lp'(1);
                    end
                end
            end
            e_issue, e_issue_fence: begin
                if (deq) begin
                    qcnt_n = '0;
                    if (count_n == '0)   state_n = e_empty;
                    else if (succ_fence) state_n = e_quiesce;
                    else                 state_n = e_issue;
                end
            end
            e_quiesce: begin
                qcnt_n = qcnt_idle;
                if (qcnt_idle == quiesce_lp) state_n = e_issue_fence;
            end
            default: state_n = e_empty;
        endcase
        if (bus.flush_i) begin
            state_n = e_empty;
            qcnt_n  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_empty;
            qcnt_r  <= '0;
            count_r <= '0;
            wptr_r  <= '0;
            rptr_r  <= '0;
        end else begin
            state_r <= state_n;
            qcnt_r  <= qcnt_n;
            count_r <= count_n;
            if (bus.flush_i) begin
                wptr_r <= '0;
                rptr_r <= '0;
            end else begin
                if (enq) wptr_r <= wptr_r + 1'b1;
                if (deq) rptr_r <= rptr_r + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) mem_r[wptr_r] <= bus.cmd_i;
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.fe_cmd_yumi_i |-> bus.fe_cmd_v_o);
    a_count_bounded: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_r <= els_lp);
endmodule

// File: tb/tb_bp_fe_cmd_sequencer.sv
// Bench for bp_fe_cmd_sequencer: vector table plus fence, flush and reset sequences,
// with a queue model of the expected command stream and occupancy.
module tb_bp_fe_cmd_sequencer;
    import bp_fe_cmd_pkg::*;

    localparam int ELS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bp_fe_cmd_sequencer_if #(.els_p(ELS)) bus();

    bp_fe_cmd_sequencer #(
        .bp_params_p(e_bp_inv_cfg),
        .els_p(ELS),
        .quiesce_cycles_p(3)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .bus(bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bp_fe_cmd_s exp_q[$];

    typedef struct {
        logic                         cmd_v;
        bp_fe_command_queue_opcodes_e op;
        logic [38:0]                  va;
        logic                         yumi;
        logic                         exp_ready;
        logic                         exp_v;
        logic [2:0]                   exp_count;
        logic                         exp_pend;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    function automatic vec_t mkv(logic v, bp_fe_command_queue_opcodes_e op, logic [38:0] va,
                                 logic y, logic er, logic ev, logic [2:0] ec, logic ep);
        vec_t r;
        r.cmd_v = v; r.op = op; r.va = va; r.yumi = y;
        r.exp_ready = er; r.exp_v = ev; r.exp_count = ec; r.exp_pend = ep;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input bp_fe_command_queue_opcodes_e op, input logic [38:0] va,
                         input logic y, input logic busy, input logic fl);
        bus.cmd_v_i       = v;
        bus.cmd_i         = '{operands: 64'h0, vaddr: va, opcode: op};
        bus.fe_cmd_yumi_i = y;
        bus.fe_busy_i     = busy;
        bus.flush_i       = fl;
    endtask

    task automatic idle(input logic busy);
        drive(1'b0, e_op_attaboy, 39'h0, 1'b0, busy, 1'b0);
    endtask

    // Runs at the negedge: checks ready/count against the model, then updates it.
    task automatic sb_update();
        bp_fe_cmd_s e;
        logic accept;
        accept = bus.cmd_v_i && (exp_q.size() < ELS) && !bus.flush_i;
        chk("model_ready", bus.cmd_ready_o, (exp_q.size() < ELS) && !bus.flush_i);
        chk("model_count", bus.count_o, exp_q.size());
        if (bus.fe_cmd_yumi_i && bus.fe_cmd_v_o) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_underflow: got a dequeue, expected no buffered command");
            end else begin
                e = exp_q.pop_front();
                chk("sb_vaddr", bus.fe_cmd_o.vaddr, e.vaddr);
                chk("sb_opcode", bus.fe_cmd_o.opcode, e.opcode);
            end
        end
        if (accept) exp_q.push_back(bus.cmd_i);
        if (bus.flush_i) exp_q.delete();
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic adv();
        sb_update();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic pend);
        chk({tag, "_v"}, bus.fe_cmd_v_o, v);
        chk({tag, "_pend"}, bus.fence_pending_o, pend);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        bit seen;

        vecs[0]  = mkv(1, e_op_pc_redirection, 39'h8000_0000, 0, 1, 0, 0, 0);
        vecs[1]  = mkv(0, e_op_attaboy, 39'h0,   1, 1, 1, 1, 0);
        vecs[2]  = mkv(0, e_op_attaboy, 39'h0,   0, 1, 0, 0, 0);
        vecs[3]  = mkv(1, e_op_attaboy, 39'h100, 0, 1, 0, 0, 0);
        vecs[4]  = mkv(1, e_op_attaboy, 39'h200, 0, 1, 1, 1, 0);
        vecs[5]  = mkv(1, e_op_attaboy, 39'h300, 0, 1, 1, 2, 0);
        vecs[6]  = mkv(1, e_op_attaboy, 39'h400, 0, 1, 1, 3, 0);
        vecs[7]  = mkv(1, e_op_attaboy, 39'h500, 0, 0, 1, 4, 0);
        vecs[8]  = mkv(1, e_op_attaboy, 39'h500, 1, 0, 1, 4, 0);
        vecs[9]  = mkv(1, e_op_attaboy, 39'h500, 0, 1, 1, 3, 0);
        vecs[10] = mkv(0, e_op_attaboy, 39'h0,   1, 0, 1, 4, 0);
        vecs[11] = mkv(0, e_op_attaboy, 39'h0,   1, 1, 1, 3, 0);
        vecs[12] = mkv(0, e_op_attaboy, 39'h0,   1, 1, 1, 2, 0);
        vecs[13] = mkv(0, e_op_attaboy, 39'h0,   1, 1, 1, 1, 0);
        vecs[14] = mkv(0, e_op_attaboy, 39'h0,   0, 1, 0, 0, 0);
        vecs[15] = mkv(1, e_op_attaboy, 39'h600, 0, 1, 0, 0, 0);
        vecs[16] = mkv(1, e_op_attaboy, 39'h700, 1, 1, 1, 1, 0);
        vecs[17] = mkv(0, e_op_attaboy, 39'h0,   1, 1, 1, 1, 0);
        vecs[18] = mkv(0, e_op_attaboy, 39'h0,   0, 1, 0, 0, 0);

        // Reset state, held in reset
        idle(1'b0);
        #3;
        chk("rst_count", bus.count_o, 0);
        chk_out("rst", 1'b0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        settle();
        chk("rst_ready", bus.cmd_ready_o, 1'b1);
        @(posedge clk); #1;

        // Redirection round trip, fill to full, overflow refusal, concurrent enq/deq
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].cmd_v, vecs[i].op, vecs[i].va, vecs[i].yumi, 1'b0, 1'b0);
            settle();
            chk($sformatf("vec%0d_ready", i), bus.cmd_ready_o, vecs[i].exp_ready);
            chk($sformatf("vec%0d_count", i), bus.count_o, vecs[i].exp_count);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_pend);
            adv();
        end

        // Fence behind 10 busy cycles: valid exactly 3 idle cycles after busy falls
        drive(1, e_op_icache_fence, 39'h7000, 0, 1, 0);
        settle(); adv();
        for (int i = 0; i < 9; i++) begin
            idle(1'b1); settle(); chk_out($sformatf("f3_busy%0d", i), 1'b0, 1'b1); adv();
        end
        for (int i = 0; i < 3; i++) begin
            idle(1'b0); settle(); chk_out($sformatf("f3_idle%0d", i), 1'b0, 1'b1); adv();
        end
        drive(0, e_op_attaboy, 39'h0, 1, 0, 0);
        settle(); chk_out("f3_present", 1'b1, 1'b0); adv();
        idle(1'b0); settle(); chk_out("f3_done", 1'b0, 1'b0); adv();

        // Busy pulse after 2 idle cycles restarts the count; busy after presentation is ignored
        drive(1, e_op_itlb_fence, 39'h7100, 0, 1, 0);
        settle(); adv();
        idle(1'b0); settle(); chk_out("f4_idle0", 1'b0, 1'b1); adv();
        idle(1'b0); settle(); chk_out("f4_idle1", 1'b0, 1'b1); adv();
        idle(1'b1); settle(); chk_out("f4_pulse", 1'b0, 1'b1); adv();
        for (int i = 0; i < 3; i++) begin
            idle(1'b0); settle(); chk_out($sformatf("f4_restart%0d", i), 1'b0, 1'b1); adv();
        end
        idle(1'b1); settle(); chk_out("f4_present", 1'b1, 1'b0); adv();
        drive(0, e_op_attaboy, 39'h0, 1, 1, 0);
        settle(); chk_out("f4_held", 1'b1, 1'b0); adv();
        idle(1'b0); settle(); chk_out("f4_done", 1'b0, 1'b0); adv();

        // Flush with coincident yumi and enqueue
        for (int i = 0; i < 3; i++) begin
            drive(1, e_op_attaboy, 39'h900 + 39'(i), 0, 0, 0);
            settle(); adv();
        end
        drive(1, e_op_attaboy, 39'h9ff, 1, 0, 1);
        settle();
        chk("fl_count_before", bus.count_o, 3);
        chk("fl_ready", bus.cmd_ready_o, 1'b0);
        adv();
        idle(1'b0); settle();
        chk("fl_count_after", bus.count_o, 0);
        chk_out("fl_after", 1'b0, 1'b0);
        adv();
        drive(1, e_op_attaboy, 39'ha00, 0, 0, 0); settle(); adv();
        drive(0, e_op_attaboy, 39'h0, 1, 0, 0);
        settle(); chk_out("fl_next", 1'b1, 1'b0); adv();
        idle(1'b0); settle(); chk("fl_next_count", bus.count_o, 0); adv();

        // Async reset while a fence is presented
        drive(1, e_op_icache_fence, 39'hb00, 0, 0, 0); settle(); adv();
        drive(1, e_op_attaboy, 39'hb10, 0, 0, 0); settle(); adv();
        idle(1'b0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            settle();
            if (bus.fe_cmd_v_o) seen = 1'b1;
            else adv();
        end
        chk("rs_fence_seen", seen, 1'b1);
        chk("rs_opcode", bus.fe_cmd_o.opcode, e_op_icache_fence);
        chk("rs_count_before", bus.count_o, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async_v", bus.fe_cmd_v_o, 1'b0);
        chk("rs_async_count", bus.count_o, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        settle();
        chk("rs_ready", bus.cmd_ready_o, 1'b1);
        chk_out("rs_release", 1'b0, 1'b0);
        adv();
        settle();
        chk_out("rs_no_replay", 1'b0, 1'b0);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
